pc_fetch_unit: RTL and testbench

- 16-bit program counter and next-PC selection stage of the single-cycle RISC datapath.
- Sits directly upstream of the 16-bit adder:
  - `pc` drives adder input A.
  - The branch offset drives adder input B.
  - The adder sum S returns to this block as `br_target`.
- Also holds a small circular return-address stack (RAS) for call/return and provides a fetch-valid indication to the instruction memory.

---
 rtl/pc_fetch_unit.sv | 131 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter, next-PC select and circular return-address stack for the
// single-cycle datapath; the branch target arrives from the external adder.
module pc_fetch_unit #(
  parameter logic [15:0] RESET_VEC = 16'h0000,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RAS_AW    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [15:0]       br_target,
  input  logic              jump_en,
  input  logic              call_en,
  input  logic              ret_en,
  input  logic [15:0]       jump_addr,
  output logic [15:0]       pc,
  output logic [15:0]       pc_plus1,
  output logic              fetch_valid,
  output logic [RAS_AW:0]   ras_count,
  output logic              ras_ovf,
  output logic              ras_unf
);

  localparam int unsigned PC_W  = 16;
  localparam int unsigned CNT_W = RAS_AW + 1;
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [RAS_AW-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                push;
  logic [PC_W-1:0]     ras_q [RAS_DEPTH];
  logic [RAS_AW-1:0]   ptr_m1;
  logic [PC_W-1:0]     pc_inc;

  assign pc_inc = pc_q + PC_W'(1);
  // ptr_q is the next free slot, so the top of stack sits one below it
  assign ptr_m1 = ptr_q - RAS_AW'(1);

  // Next-state and next-PC selection
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (stall) begin
          pc_d = pc_q;
        end else if (ret_en) begin
          if (cnt_q != '0) begin
            pc_d  = ras_q[ptr_m1];
            ptr_d = ptr_m1;
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
          end
        end else if (call_en) begin
          // When full, ptr_q already points at the oldest entry, so the push overwrites it
          push  = 1'b1;
          pc_d  = jump_addr;
          ptr_d = ptr_q + RAS_AW'(1);
          if (cnt_q == RAS_FULL) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (jump_en) begin
          pc_d = jump_addr;
        end else if (branch_en) begin
          pc_d = br_target;
        end else begin
          pc_d = pc_inc;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Control and pointer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VEC;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-address storage, cleared so a read can never expose X
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_q[i] <= '0;
      end
    end else if (push) begin
      ras_q[ptr_q] <= pc_inc;
    end
  end

  assign pc          = pc_q;
  assign pc_plus1    = pc_inc;
  assign fetch_valid = (state_q == ST_RUN);
  assign ras_count   = cnt_q;
  assign ras_ovf     = ovf_q;
  assign ras_unf     = unf_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed steps queue hand-computed
// expectations, a monitor compares them one edge later.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_en;
  logic [15:0] br_target;
  logic        jump_en;
  logic        call_en;
  logic        ret_en;
  logic [15:0] jump_addr;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        fetch_valid;
  logic [2:0]  ras_count;
  logic        ras_ovf;
  logic        ras_unf;
  logic [15:0] offset;

  int checks = 0;
  int errors = 0;
  int step_id = 0;

  typedef struct packed {
    logic [31:0] id;
    logic [15:0] pc;
    logic        fv;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  localparam logic [4:0] C_IDLE = 5'b00000;
  localparam logic [4:0] C_BR   = 5'b00001;
  localparam logic [4:0] C_JP   = 5'b00010;
  localparam logic [4:0] C_CL   = 5'b00100;
  localparam logic [4:0] C_RT   = 5'b01000;
  localparam logic [4:0] C_ST   = 5'b10000;

  pc_fetch_unit #(
    .RESET_VEC (16'h0000),
    .RAS_DEPTH (4),
    .RAS_AW    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .branch_en   (branch_en),
    .br_target   (br_target),
    .jump_en     (jump_en),
    .call_en     (call_en),
    .ret_en      (ret_en),
    .jump_addr   (jump_addr),
    .pc          (pc),
    .pc_plus1    (pc_plus1),
    .fetch_valid (fetch_valid),
    .ras_count   (ras_count),
    .ras_ovf     (ras_ovf),
    .ras_unf     (ras_unf)
  );

  // External 16-bit adder: A = pc, B = branch offset, carry out dropped
  assign br_target = 16'(pc + offset);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  // Monitor: one expectation per active edge while the queue holds any
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if ({pc, pc_plus1, fetch_valid, ras_count, ras_ovf, ras_unf} !==
          {mon_e.pc, 16'(mon_e.pc + 16'd1), mon_e.fv, mon_e.cnt, mon_e.ovf, mon_e.unf}) begin
        errors++;
        $display("FAIL step%0d: got pc=%h pp1=%h fv=%b cnt=%0d ovf=%b unf=%b, want pc=%h pp1=%h fv=%b cnt=%0d ovf=%b unf=%b",
                 mon_e.id, pc, pc_plus1, fetch_valid, ras_count, ras_ovf, ras_unf,
                 mon_e.pc, 16'(mon_e.pc + 16'd1), mon_e.fv, mon_e.cnt, mon_e.ovf, mon_e.unf);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Drive one cycle of controls (ctrl = {stall, ret, call, jump, branch}) and
  // queue the state expected after the following rising edge.
  task automatic step(input logic [4:0] c, input logic [15:0] ja, input logic [15:0] off,
                      input logic [15:0] epc, input logic [2:0] ecnt,
                      input logic eovf, input logic eunf);
    exp_t e;
    {stall, ret_en, call_en, jump_en, branch_en} = c;
    jump_addr = ja;
    offset    = off;
    step_id++;
    e.id  = 32'(step_id);
    e.pc  = epc;
    e.fv  = 1'b1;
    e.cnt = ecnt;
    e.ovf = eovf;
    e.unf = eunf;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    {stall, ret_en, call_en, jump_en, branch_en} = C_IDLE;
    jump_addr = 16'h0000;
    offset    = 16'h0000;
    #1;
    chk("reset_pc", 32'(pc), 32'h0000);
    chk("reset_fv", 32'(fetch_valid), 32'h0);
    chk("reset_cnt_flags", 32'({ras_count, ras_ovf, ras_unf}), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    // First edge only raises fetch_valid; PC stays at the reset vector
    step(C_IDLE, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
    step(C_IDLE, 16'h0000, 16'h0000, 16'h0001, 3'd0, 1'b0, 1'b0);
    step(C_IDLE, 16'h0000, 16'h0000, 16'h0002, 3'd0, 1'b0, 1'b0);
    step(C_IDLE, 16'h0000, 16'h0000, 16'h0003, 3'd0, 1'b0, 1'b0);

    // Branch through the adder
    step(C_JP,   16'h0012, 16'h0000, 16'h0012, 3'd0, 1'b0, 1'b0);
    step(C_BR,   16'h0000, 16'h0034, 16'h0046, 3'd0, 1'b0, 1'b0);
    step(C_JP,   16'h0056, 16'h0000, 16'h0056, 3'd0, 1'b0, 1'b0);
    step(C_BR,   16'h0000, 16'h0078, 16'h00CE, 3'd0, 1'b0, 1'b0);

    // Nested call/return
    step(C_JP,   16'h0010, 16'h0000, 16'h0010, 3'd0, 1'b0, 1'b0);
    step(C_IDLE, 16'h0000, 16'h0000, 16'h0011, 3'd0, 1'b0, 1'b0);
    step(C_CL,   16'h0100, 16'h0000, 16'h0100, 3'd1, 1'b0, 1'b0);
    step(C_IDLE, 16'h0000, 16'h0000, 16'h0101, 3'd1, 1'b0, 1'b0);
    step(C_CL,   16'h0200, 16'h0000, 16'h0200, 3'd2, 1'b0, 1'b0);
    step(C_RT,   16'h0000, 16'h0000, 16'h0102, 3'd1, 1'b0, 1'b0);
    step(C_RT,   16'h0000, 16'h0000, 16'h0012, 3'd0, 1'b0, 1'b0);

    // Five calls overflow a 4-deep stack; the return to 0013 is lost
    step(C_CL,   16'h1000, 16'h0000, 16'h1000, 3'd1, 1'b0, 1'b0);
    step(C_CL,   16'h2000, 16'h0000, 16'h2000, 3'd2, 1'b0, 1'b0);
    step(C_CL,   16'h3000, 16'h0000, 16'h3000, 3'd3, 1'b0, 1'b0);
    step(C_CL,   16'h4000, 16'h0000, 16'h4000, 3'd4, 1'b0, 1'b0);
    step(C_CL,   16'h5000, 16'h0000, 16'h5000, 3'd4, 1'b1, 1'b0);
    step(C_RT,   16'h0000, 16'h0000, 16'h4001, 3'd3, 1'b1, 1'b0);
    step(C_RT,   16'h0000, 16'h0000, 16'h3001, 3'd2, 1'b1, 1'b0);
    step(C_RT,   16'h0000, 16'h0000, 16'h2001, 3'd1, 1'b1, 1'b0);
    step(C_RT,   16'h0000, 16'h0000, 16'h1001, 3'd0, 1'b1, 1'b0);
    step(C_RT,   16'h0000, 16'h0000, 16'h1002, 3'd0, 1'b1, 1'b1);

    // Stall dominates everything; then ret beats call with no push
    step(C_CL,   16'h0300, 16'h0000, 16'h0300, 3'd1, 1'b1, 1'b1);
    step(C_ST | C_BR | C_JP | C_RT, 16'h0ABC, 16'h0005, 16'h0300, 3'd1, 1'b1, 1'b1);
    step(C_ST | C_CL, 16'h0ABC, 16'h0005, 16'h0300, 3'd1, 1'b1, 1'b1);
    step(C_CL | C_RT, 16'h0400, 16'h0000, 16'h1003, 3'd0, 1'b1, 1'b1);
    step(C_RT,   16'h0000, 16'h0000, 16'h1004, 3'd0, 1'b1, 1'b1);

    // Jump beats branch; call beats jump
    step(C_JP | C_BR, 16'h0500, 16'h0010, 16'h0500, 3'd0, 1'b1, 1'b1);
    step(C_CL | C_JP, 16'h0600, 16'h0000, 16'h0600, 3'd1, 1'b1, 1'b1);
    step(C_RT,   16'h0000, 16'h0000, 16'h0501, 3'd0, 1'b1, 1'b1);

    // PC wraps silently
    step(C_JP,   16'hFFFF, 16'h0000, 16'hFFFF, 3'd0, 1'b1, 1'b1);
    step(C_IDLE, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b1);
    step(C_CL,   16'h0700, 16'h0000, 16'h0700, 3'd1, 1'b1, 1'b1);
    {stall, ret_en, call_en, jump_en, branch_en} = C_IDLE;

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_pc", 32'(pc), 32'h0000);
    chk("async_cnt", 32'(ras_count), 32'h0);
    chk("async_fv_flags", 32'({fetch_valid, ras_ovf, ras_unf}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(C_IDLE, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
    step(C_IDLE, 16'h0000, 16'h0000, 16'h0001, 3'd0, 1'b0, 1'b0);
    step(C_RT,   16'h0000, 16'h0000, 16'h0002, 3'd0, 1'b0, 1'b1);

    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
